// File: rtl/ram_burst_pkg.sv
// Shared state encoding and default widths for the RAM burst controller.
package ram_burst_pkg;

   localparam int AWIDTH_DEF = 3;
   localparam int DWIDTH_DEF = 32;
   localparam int LWIDTH_DEF = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2
   } state_t;

endpackage

// File: rtl/ram_burst_addr_gen.sv
// Burst address/beat tracking and RAM address select; the next address is
// driven early on a read handshake so the sync-read RAM keeps up at one beat/cycle.
module ram_burst_addr_gen
   import ram_burst_pkg::*;
#(
   parameter int AWIDTH = AWIDTH_DEF,
   parameter int LWIDTH = LWIDTH_DEF
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              i_load,
   input  logic [AWIDTH-1:0] i_req_addr,
   input  logic [LWIDTH-1:0] i_req_len,
   input  logic              i_advance,
   input  logic              i_sel_req,
   input  logic              i_sel_next,
   output logic [AWIDTH-1:0] o_ram_addr,
   output logic              o_is_last
);

   localparam logic [AWIDTH-1:0] ONE_A = AWIDTH'(1);
   localparam logic [LWIDTH-1:0] ONE_L = LWIDTH'(1);

   logic [AWIDTH-1:0] r_cur_addr;
   logic [LWIDTH-1:0] r_beat_cnt;
   logic [LWIDTH-1:0] r_last_len;
   logic [AWIDTH-1:0] w_addr_inc;

   assign w_addr_inc = r_cur_addr + ONE_A;
   assign o_is_last  = (r_beat_cnt == r_last_len);
   assign o_ram_addr = i_sel_req  ? i_req_addr :
                       i_sel_next ? w_addr_inc : r_cur_addr;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_cur_addr <= '0;
         r_beat_cnt <= '0;
         r_last_len <= '0;
      end else if (i_load) begin
         r_cur_addr <= i_req_addr;
         r_beat_cnt <= '0;
         r_last_len <= i_req_len;
      end else if (i_advance) begin
         r_cur_addr <= w_addr_inc;
         r_beat_cnt <= r_beat_cnt + ONE_L;
      end
   end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst read/write sequencer for a single-port sync-read RAM, one beat per cycle.
// RAM_BURST_CTRL_NOWRAP_EN: reject bursts that would wrap past the top address.
module ram_burst_ctrl
   import ram_burst_pkg::*;
#(
   parameter int AWIDTH = AWIDTH_DEF,
   parameter int DWIDTH = DWIDTH_DEF,
   parameter int LWIDTH = LWIDTH_DEF
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [AWIDTH-1:0] req_addr,
   input  logic [LWIDTH-1:0] req_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DWIDTH-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DWIDTH-1:0] rd_data,
   output logic              rd_last,
   output logic              busy,
   output logic              err,
   output logic [AWIDTH-1:0] ram_addr,
   output logic [DWIDTH-1:0] ram_din,
   output logic              ram_we,
   input  logic [DWIDTH-1:0] ram_dout
);

   state_t r_state;
   logic   r_rd_pend;
   logic   w_idle;
   logic   w_wr_hs;
   logic   w_rd_hs;
   logic   w_is_last;
   logic   w_reject;

`ifdef RAM_BURST_CTRL_NOWRAP_EN
   localparam int SW = AWIDTH + LWIDTH + 1;
   localparam logic [SW-1:0] MAX_ADDR = SW'((1 << AWIDTH) - 1);
   logic [SW-1:0] w_end_addr;
   logic          r_err;

   assign w_end_addr = SW'(req_addr) + SW'(req_len);
   assign w_reject   = (w_end_addr > MAX_ADDR);
   assign err        = r_err;
`else
   assign w_reject   = 1'b0;
   assign err        = 1'b0;
`endif

   assign w_idle  = (r_state == ST_IDLE);
   assign w_wr_hs = (r_state == ST_WRITE) && wr_valid;
   assign w_rd_hs = (r_state == ST_READ) && r_rd_pend && rd_ready;

   assign req_ready = w_idle;
   assign wr_ready  = (r_state == ST_WRITE);
   assign busy      = !w_idle;
   assign rd_valid  = r_rd_pend;
   assign rd_last   = r_rd_pend && w_is_last;
   assign rd_data   = ram_dout;
   assign ram_din   = wr_data;
   assign ram_we    = w_wr_hs;

   ram_burst_addr_gen #(
      .AWIDTH (AWIDTH),
      .LWIDTH (LWIDTH)
   ) u_addr_gen (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_load     (w_idle && req_valid && !w_reject),
      .i_req_addr (req_addr),
      .i_req_len  (req_len),
      .i_advance  (w_wr_hs || (w_rd_hs && !w_is_last)),
      .i_sel_req  (w_idle),
      .i_sel_next (w_rd_hs && !w_is_last),
      .o_ram_addr (ram_addr),
      .o_is_last  (w_is_last)
   );

   // rd_pend covers the whole read burst; the RAM already holds the first beat
   // by the cycle after acceptance.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_rd_pend <= 1'b0;
`ifdef RAM_BURST_CTRL_NOWRAP_EN
         r_err     <= 1'b0;
`endif
      end else begin
`ifdef RAM_BURST_CTRL_NOWRAP_EN
         r_err <= w_idle && req_valid && w_reject;
`endif
         case (r_state)
            ST_IDLE: begin
               if (req_valid && !w_reject) begin
                  r_state   <= req_write ? ST_WRITE : ST_READ;
                  r_rd_pend <= !req_write;
               end
            end
            ST_WRITE: begin
               if (wr_valid && w_is_last) r_state <= ST_IDLE;
            end
            ST_READ: begin
               if (w_rd_hs && w_is_last) begin
                  r_state   <= ST_IDLE;
                  r_rd_pend <= 1'b0;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_rd_pend <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl with a behavioural sync-read RAM attached.
module tb_ram_burst_ctrl;

   localparam int AW = 3;
   localparam int DW = 32;
   localparam int LW = 3;

   logic          clock;
   logic          reset_n;
   logic          req_valid, req_ready, req_write;
   logic [AW-1:0] req_addr;
   logic [LW-1:0] req_len;
   logic          wr_valid, wr_ready;
   logic [DW-1:0] wr_data;
   logic          rd_valid, rd_ready, rd_last;
   logic [DW-1:0] rd_data;
   logic          busy, err;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din, ram_dout;
   logic          ram_we;
   logic          preload;

   logic [DW-1:0] mem [0:7];

   int n_chk  = 0;
   int n_fail = 0;

   ram_burst_ctrl dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_data   (wr_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .rd_last   (rd_last),
      .busy      (busy),
      .err       (err),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_we    (ram_we),
      .ram_dout  (ram_dout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (preload) begin
         for (int i = 0; i < 8; i++) mem[i] <= 32'h100 + i;
      end else if (ram_we) begin
         mem[ram_addr] <= ram_din;
      end
      ram_dout <= mem[ram_addr];
   end

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; preload = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
      wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
      step; step;
      preload = 1'b0;
      n_chk++;
      if ({req_ready, wr_ready, rd_valid, rd_last, busy, err, ram_we} !== 7'b1000000) begin
         n_fail++;
         $display("FAIL reset_in got %b exp 1000000", {req_ready, wr_ready, rd_valid, rd_last, busy, err, ram_we});
      end
      reset_n = 1'b1;
      step;
      n_chk++;
      if ({req_ready, wr_ready, rd_valid, rd_last, busy, err, ram_we} !== 7'b1000000) begin
         n_fail++;
         $display("FAIL reset_after got %b exp 1000000", {req_ready, wr_ready, rd_valid, rd_last, busy, err, ram_we});
      end
   endtask

   task automatic test_write_read;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd2; req_len = 3'd3;
      #1;
      n_chk++;
      if ({req_ready, ram_addr, ram_we} !== {1'b1, 3'd2, 1'b0}) begin
         n_fail++;
         $display("FAIL wr_req got rdy=%b addr=%0d we=%b exp 1 2 0", req_ready, ram_addr, ram_we);
      end
      step;
      req_valid = 1'b0; wr_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wr_data = 32'hA0 + i;
         #1;
         n_chk++;
         if ({wr_ready, ram_we, busy, req_ready, ram_addr} !== {4'b1110, 3'(2 + i)}) begin
            n_fail++;
            $display("FAIL wr_beat%0d got %b exp %b", i, {wr_ready, ram_we, busy, req_ready, ram_addr}, {4'b1110, 3'(2 + i)});
         end
         step;
      end
      wr_valid = 1'b0;
      #1;
      n_chk++;
      if ({busy, req_ready, wr_ready, ram_we} !== 4'b0100) begin
         n_fail++;
         $display("FAIL wr_end got %b exp 0100", {busy, req_ready, wr_ready, ram_we});
      end
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if (mem[2 + i] !== 32'hA0 + i) begin
            n_fail++;
            $display("FAIL wr_mem%0d got %h exp %h", 2 + i, mem[2 + i], 32'hA0 + i);
         end
      end
      req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd2; req_len = 3'd3; rd_ready = 1'b1;
      step;
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if ({rd_valid, rd_last, rd_data} !== {1'b1, (i == 3), 32'hA0 + i}) begin
            n_fail++;
            $display("FAIL rd_beat%0d got v=%b l=%b d=%h exp 1 %0d %h", i, rd_valid, rd_last, rd_data, (i == 3), 32'hA0 + i);
         end
         step;
      end
      n_chk++;
      if ({rd_valid, busy, req_ready} !== 3'b001) begin
         n_fail++;
         $display("FAIL rd_end got %b exp 001", {rd_valid, busy, req_ready});
      end
   endtask

   task automatic test_read_stall;
      logic [5:0] pat;
      int k;
      pat = 6'b111001;
      k = 0;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd2; req_len = 3'd3;
      step;
      req_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         rd_ready = pat[c];
         #1;
         n_chk++;
         if ({rd_valid, rd_last, rd_data, ram_addr} !==
             {1'b1, (k == 3), 32'hA0 + k, ((pat[c] && k != 3) ? 3'(3 + k) : 3'(2 + k))}) begin
            n_fail++;
            $display("FAIL stall_c%0d got v=%b l=%b d=%h a=%0d exp beat %0d", c, rd_valid, rd_last, rd_data, ram_addr, k);
         end
         step;
         if (pat[c]) k++;
      end
      rd_ready = 1'b1;
      #1;
      n_chk++;
      if ({rd_valid, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL stall_end got %b exp 00", {rd_valid, busy});
      end
   endtask

   task automatic test_write_gaps;
      logic [3:0] pat;
      int n;
      pat = 4'b1101;
      n = 0;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd0; req_len = 3'd2;
      step;
      req_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         wr_valid = pat[c];
         wr_data  = 32'hB0 + c;
         #1;
         n_chk++;
         if ({ram_we, busy, ram_addr} !== {pat[c], 1'b1, 3'(n)}) begin
            n_fail++;
            $display("FAIL gap_c%0d got we=%b busy=%b a=%0d exp %b 1 %0d", c, ram_we, busy, ram_addr, pat[c], n);
         end
         step;
         if (pat[c]) n++;
      end
      wr_valid = 1'b0;
      #1;
      n_chk++;
      if ({busy, ram_we} !== 2'b00) begin
         n_fail++;
         $display("FAIL gap_end got %b exp 00", {busy, ram_we});
      end
      n_chk++;
      if ({mem[0], mem[1], mem[2], mem[3]} !== {32'hB0, 32'hB2, 32'hB3, 32'hA1}) begin
         n_fail++;
         $display("FAIL gap_mem got %h %h %h %h exp b0 b2 b3 a1", mem[0], mem[1], mem[2], mem[3]);
      end
   endtask

   task automatic test_wrap;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd6; req_len = 3'd3;
`ifdef RAM_BURST_CTRL_NOWRAP_EN
      step;
      req_valid = 1'b0;
      #1;
      n_chk++;
      if ({err, busy, ram_we, req_ready} !== 4'b1001) begin
         n_fail++;
         $display("FAIL nowrap_err got %b exp 1001", {err, busy, ram_we, req_ready});
      end
      step;
      n_chk++;
      if ({err, busy, ram_we} !== 3'b000) begin
         n_fail++;
         $display("FAIL nowrap_clr got %b exp 000", {err, busy, ram_we});
      end
      n_chk++;
      if ({mem[6], mem[7]} !== {32'h106, 32'h107}) begin
         n_fail++;
         $display("FAIL nowrap_mem got %h %h exp 106 107", mem[6], mem[7]);
      end
`else
      step;
      req_valid = 1'b0; wr_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wr_data = 32'hC0 + i;
         #1;
         n_chk++;
         if ({ram_we, ram_addr} !== {1'b1, 3'(6 + i)}) begin
            n_fail++;
            $display("FAIL wrap_beat%0d got we=%b a=%0d exp 1 %0d", i, ram_we, ram_addr, 3'(6 + i));
         end
         step;
      end
      wr_valid = 1'b0;
      #1;
      n_chk++;
      if ({mem[6], mem[7], mem[0], mem[1], busy, err} !== {32'hC0, 32'hC1, 32'hC2, 32'hC3, 2'b00}) begin
         n_fail++;
         $display("FAIL wrap_mem got %h %h %h %h busy=%b err=%b", mem[6], mem[7], mem[0], mem[1], busy, err);
      end
`endif
   endtask

   task automatic test_reset_mid;
      preload = 1'b1;
      step;
      preload = 1'b0;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd0; req_len = 3'd5; rd_ready = 1'b1;
      step;
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_chk++;
         if ({rd_valid, rd_data} !== {1'b1, 32'h100 + i}) begin
            n_fail++;
            $display("FAIL rmid_beat%0d got v=%b d=%h exp 1 %h", i, rd_valid, rd_data, 32'h100 + i);
         end
         step;
      end
      reset_n = 1'b0;
      step;
      n_chk++;
      if ({req_ready, rd_valid, rd_last, busy, ram_we, err} !== 6'b100000) begin
         n_fail++;
         $display("FAIL rmid_reset got %b exp 100000", {req_ready, rd_valid, rd_last, busy, ram_we, err});
      end
      reset_n = 1'b1;
      req_valid = 1'b1; req_addr = 3'd0; req_len = 3'd1;
      step;
      req_valid = 1'b0;
      n_chk++;
      if ({rd_valid, rd_last, rd_data} !== {2'b10, 32'h100}) begin
         n_fail++;
         $display("FAIL rmid_re0 got v=%b l=%b d=%h exp 1 0 100", rd_valid, rd_last, rd_data);
      end
      step;
      n_chk++;
      if ({rd_valid, rd_last, rd_data} !== {2'b11, 32'h101}) begin
         n_fail++;
         $display("FAIL rmid_re1 got v=%b l=%b d=%h exp 1 1 101", rd_valid, rd_last, rd_data);
      end
      step;
   endtask

   task automatic test_back_to_back;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd4; req_len = 3'd1; rd_ready = 1'b1;
      #1;
      n_chk++;
      if ({req_ready, busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL b2b_c0 got %b exp 10", {req_ready, busy});
      end
      step;
      req_addr = 3'd6; req_len = 3'd0;
      #1;
      n_chk++;
      if ({req_ready, rd_valid, rd_last, rd_data} !== {3'b010, 32'h104}) begin
         n_fail++;
         $display("FAIL b2b_c1 got rdy=%b v=%b l=%b d=%h exp 0 1 0 104", req_ready, rd_valid, rd_last, rd_data);
      end
      step;
      n_chk++;
      if ({req_ready, rd_valid, rd_last, rd_data} !== {3'b011, 32'h105}) begin
         n_fail++;
         $display("FAIL b2b_c2 got rdy=%b v=%b l=%b d=%h exp 0 1 1 105", req_ready, rd_valid, rd_last, rd_data);
      end
      step;
      n_chk++;
      if ({req_ready, busy, rd_valid} !== 3'b100) begin
         n_fail++;
         $display("FAIL b2b_c3 got %b exp 100", {req_ready, busy, rd_valid});
      end
      step;
      req_valid = 1'b0;
      #1;
      n_chk++;
      if ({req_ready, busy, rd_valid, rd_last, rd_data} !== {4'b0111, 32'h106}) begin
         n_fail++;
         $display("FAIL b2b_c4 got rdy=%b b=%b v=%b l=%b d=%h exp 0 1 1 1 106", req_ready, busy, rd_valid, rd_last, rd_data);
      end
      step;
      n_chk++;
      if ({req_ready, busy, rd_valid} !== 3'b100) begin
         n_fail++;
         $display("FAIL b2b_c5 got %b exp 100", {req_ready, busy, rd_valid});
      end
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_read_stall;
      test_write_gaps;
      test_wrap;
      test_reset_mid;
      test_back_to_back;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
